// File: rtl/mem_arbiter.sv
// Round-robin two-master sequencer for a single-ported synchronous memory: grant at t, memory access at t+1, rvalid/rdata at t+3.
// One transaction in flight; a requester simply holds req until its combinational gnt, and no grant is given during ISSUE.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    state_t state, state_nxt;
    req_t   hold, cand;
    logic   owner, last_owner;
    logic   any_req, winner, grant;

    assign any_req = m0_req | m1_req;
    // On a tie the master that did not win last time takes the bus.
    assign winner  = (m0_req & m1_req) ? ~last_owner : m1_req;
    assign cand    = winner ? req_t'{m1_we, m1_addr, m1_wdata}
                            : req_t'{m0_we, m0_addr, m0_wdata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = RESP;
            end
            RESP: begin
                grant     = any_req;
                state_nxt = any_req ? ISSUE : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        m0_gnt = grant & ~winner;
        m1_gnt = grant & winner;
        mem_we = (state == ISSUE) & hold.we;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= 1'b0;
            last_owner <= 1'b1;
            hold       <= '0;
            m0_rvalid  <= 1'b0;
            m1_rvalid  <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            m0_rvalid <= (state == RESP) & ~owner;
            m1_rvalid <= (state == RESP) & owner;
            // Memory data is valid during RESP; writes leave rdata untouched.
            if (state == RESP && !hold.we) begin
                if (owner) begin
                    m1_rdata <= mem_rdata;
                end else begin
                    m0_rdata <= mem_rdata;
                end
            end
            if (grant) begin
                owner      <= winner;
                last_owner <= winner;
                hold       <= cand;
            end
        end
    end

    assign mem_addr  = hold.addr;
    assign mem_wdata = hold.wdata;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vectors with literal expectations plus a per-cycle transaction-history model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we, busy;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'h0050_0093 : 32'h1000_0000 + i;
    endfunction

    // Synchronous single-port RAM seen by the DUT (64 words, reset-independent).
    logic [31:0] ram_dat [64];
    bit          ram_wr  [64];

    function automatic logic [31:0] ram_rd(input logic [5:0] i);
        return ram_wr[i] ? ram_dat[i] : init_word(int'(i));
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            ram_dat[mem_addr[7:2]] <= mem_wdata;
            ram_wr[mem_addr[7:2]]  <= 1'b1;
        end
        mem_rdata <= ram_rd(mem_addr[7:2]);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // h1/h2/h3 hold the transactions granted one, two and three cycles ago.
    typedef struct packed {
        bit          v;
        bit          own;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t        h1, h2, h3, pend;
    bit          lo = 1'b1;
    logic [31:0] cur_addr = '0, cur_wdata = '0;
    logic [31:0] rd [2];
    logic [31:0] ref_dat [64];
    bit          ref_wr  [64];
    bit          rst_at_edge = 1'b1;

    always @(posedge clk) rst_at_edge <= reset;

    task automatic model_clear();
        h1 = '0; h2 = '0; h3 = '0;
        lo = 1'b1; cur_addr = '0; cur_wdata = '0;
        rd[0] = '0; rd[1] = '0;
    endtask

    initial begin
        logic [5:0] ix;
        bit         both;
        model_clear();
        pend = '0;
        forever begin
            @(negedge clk);
            // Apply the clock edge that just passed.
            if (rst_at_edge) begin
                model_clear();
            end else begin
                if (h1.v) begin
                    ix = h1.addr[7:2];
                    if (h1.we) begin
                        ref_dat[ix] = h1.wdata;
                        ref_wr[ix]  = 1'b1;
                    end else begin
                        h1.rdata = ref_wr[ix] ? ref_dat[ix] : init_word(int'(ix));
                    end
                end
                if (h2.v && !h2.we) rd[h2.own] = h2.rdata;
                h3 = h2;
                h2 = h1;
                h1 = pend;
                if (pend.v) begin
                    lo        = pend.own;
                    cur_addr  = pend.addr;
                    cur_wdata = pend.wdata;
                end
            end
            if (reset) model_clear();
            // Decide this cycle's grant: bus is free unless a grant happened last cycle.
            pend = '0;
            both = m0_req && m1_req;
            if (!h1.v && (m0_req || m1_req)) begin
                pend.v     = 1'b1;
                pend.own   = both ? ~lo : m1_req;
                pend.we    = pend.own ? m1_we : m0_we;
                pend.addr  = pend.own ? m1_addr : m0_addr;
                pend.wdata = pend.own ? m1_wdata : m0_wdata;
            end
            chk("model_m0_gnt", m0_gnt, pend.v && !pend.own);
            chk("model_m1_gnt", m1_gnt, pend.v && pend.own);
            chk("model_mem_we", mem_we, h1.v && h1.we);
            chk("model_mem_addr", mem_addr, cur_addr);
            chk("model_mem_wdata", mem_wdata, cur_wdata);
            chk("model_busy", busy, h1.v || h2.v);
            chk("model_m0_rvalid", m0_rvalid, h3.v && !h3.own);
            chk("model_m1_rvalid", m1_rvalid, h3.v && h3.own);
            chk("model_m0_rdata", m0_rdata, rd[0]);
            chk("model_m1_rdata", m1_rdata, rd[1]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end

    initial begin
        logic [7:0] g0, g1, v0, v1;
        int         rvcnt;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        mid();
        chk("rst_busy", busy, 0);
        chk("rst_mem", {mem_we, mem_addr, mem_wdata}, 0);
        chk("rst_rv", {m0_rvalid, m1_rvalid}, 0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
        cyc(); reset = 1'b0;

        // m0 read of 0x10
        cyc(); m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        mid(); chk("t1_gnt", {m0_gnt, m1_gnt}, 2'b10);
        cyc(); m0_req = 0;
        mid(); chk("t1_addr", mem_addr, 32'h10); chk("t1_we", mem_we, 0);
        cyc(); mid(); chk("t1_rv_early", m0_rvalid, 0);
        cyc(); mid();
        chk("t1_rvalid", m0_rvalid, 1);
        chk("t1_rdata", m0_rdata, 32'h0050_0093);
        chk("t1_m1_quiet", {m1_rvalid, m1_rdata}, 0);
        cyc(); mid(); chk("t1_rv_pulse", m0_rvalid, 0);

        // m1 write 0x20, then m0 readback
        cyc(); m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'hDEAD_BEEF;
        mid(); chk("t2_gnt", m1_gnt, 1); chk("t2_we_gnt", mem_we, 0);
        cyc(); m1_req = 0; m1_we = 0;
        mid();
        chk("t2_we", mem_we, 1);
        chk("t2_addr", mem_addr, 32'h20);
        chk("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
        cyc(); mid(); chk("t2_we_resp", mem_we, 0);
        cyc(); mid();
        chk("t2_rvalid", m1_rvalid, 1);
        chk("t2_rdata_kept", m1_rdata, 0);
        cyc(); m0_req = 1; m0_addr = 32'h20;
        mid(); chk("t2_rb_gnt", m0_gnt, 1);
        cyc(); m0_req = 0;
        cyc(); cyc(); mid();
        chk("t2_rb_rv", m0_rvalid, 1);
        chk("t2_rb_data", m0_rdata, 32'hDEAD_BEEF);

        // Continuous contention from reset
        cyc(); reset = 1;
        cyc(); cyc(); reset = 0;
        cyc(); m0_req = 1; m0_addr = 32'h0; m1_req = 1; m1_addr = 32'h4;
        for (int i = 0; i < 8; i++) begin
            mid();
            g0[i] = m0_gnt; g1[i] = m1_gnt; v0[i] = m0_rvalid; v1[i] = m1_rvalid;
            cyc();
        end
        m0_req = 0; m1_req = 0;
        chk("t3_g0", g0, 8'h11);
        chk("t3_g1", g1, 8'h44);
        chk("t3_rv0", v0, 8'h88);
        chk("t3_rv1", v1, 8'h20);
        repeat (3) cyc();
        mid();
        chk("t3_rd0", m0_rdata, 32'h1000_0000);
        chk("t3_rd1", m1_rdata, 32'h1000_0001);

        // m0 waiting during an m1 ISSUE
        cyc(); m1_req = 1; m1_addr = 32'h8;
        mid(); chk("t4_m1_gnt", m1_gnt, 1);
        cyc(); m1_req = 0; m0_req = 1; m0_addr = 32'h10;
        mid(); chk("t4_no_gnt_issue", m0_gnt, 0);
        cyc(); mid(); chk("t4_gnt_resp", m0_gnt, 1);
        cyc(); m0_req = 0;
        mid();
        chk("t4_m0_issue", {busy, mem_addr}, {1'b1, 32'h10});
        chk("t4_m1_done", {m1_rvalid, m1_rdata}, {1'b1, 32'h1000_0002});
        cyc(); cyc(); mid();
        chk("t4_m0_done", {m0_rvalid, m0_rdata}, {1'b1, 32'h0050_0093});

        // Reset during ISSUE of a write
        cyc(); m0_req = 1; m0_we = 1; m0_addr = 32'h30; m0_wdata = 32'h1234_5678;
        mid(); chk("t5_gnt", m0_gnt, 1);
        cyc(); m0_req = 0; m0_we = 0;
        mid(); chk("t5_we_issue", mem_we, 1);
        #1 reset = 1;
        #1 chk("t5_we_drop", {mem_we, busy}, 0);
        cyc(); mid(); chk("t5_rst_rdata", m0_rdata, 0);
        cyc(); reset = 0;
        rvcnt = 0;
        for (int i = 0; i < 4; i++) begin
            mid(); rvcnt += int'(m0_rvalid) + int'(m1_rvalid);
            cyc();
        end
        chk("t5_no_rvalid", rvcnt, 0);
        m0_req = 1; m0_addr = 32'h30; m1_req = 1; m1_addr = 32'h4;
        mid(); chk("t5_tie", {m0_gnt, m1_gnt}, 2'b10);
        cyc(); m0_req = 0;
        cyc(); mid(); chk("t5_m1_next", m1_gnt, 1);
        cyc(); m1_req = 0;
        repeat (4) cyc();
        mid(); chk("t5_not_written", m0_rdata, 32'h1000_000C);

        // Idle bus
        for (int i = 0; i < 10; i++) begin
            cyc(); mid();
            chk("t6_idle", {busy, mem_we, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single-ported synchronous data/instruction memory shared by the multicycle RISC-V core and a second master (program loader / DMA). Accepts one transaction at a time from either requester, drives the memory port for exactly one cycle per access, and returns registered read data with a valid pulse. Ties are resolved round-robin so neither master can starve the other.

## Interface
- AW, 32, address width of requesters and memory.
- DW, 32, data width.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- mK_req  in  1  (K = 0,1) transaction request; held with its mK_we/addr/wdata until mK_gnt seen.
- mK_we  in  1  1 = write, 0 = read.
- mK_addr  in  AW  byte address.
- mK_wdata  in  DW  write data.
- mK_gnt  out  1  combinational accept pulse; request captured at this edge.
- mK_rvalid  out  1  registered one-cycle completion pulse (reads and writes).
- mK_rdata  out  DW  registered read data; updated only on read completion for that master.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DW  memory read data, valid one cycle after address presented.
- busy  out  1  high in ISSUE or RESP.

## Operation
- State machine: IDLE, ISSUE, RESP. Holding regs: owner (1 bit), h_we, h_addr, h_wdata, last_owner.
- Arbitration (in IDLE and RESP only): one requester -> it wins; both -> winner = ~last_owner. Winner's gnt high that cycle; on the edge, owner/last_owner <= winner, h_* <= winner's inputs, state <= ISSUE. No request -> IDLE.
- gnt never asserted in ISSUE; at most one gnt high per cycle.
- ISSUE: mem_addr = h_addr, mem_wdata = h_wdata, mem_we = h_we. State <= RESP unconditionally.
- RESP: mem_we = 0. On the edge: if !h_we, m[owner]_rdata <= mem_rdata; m[owner]_rvalid <= 1 for next cycle. Arbitrate again: new winner -> ISSUE, else IDLE.
- mem_we is 0 outside ISSUE. mem_addr/mem_wdata hold h_addr/h_wdata in all states.
- Writes: rvalid still pulses (write ack); rdata unchanged.
- Other master's rdata never modified.

## Timing
- Reset values: state IDLE, last_owner = 1 (m0 wins first tie), owner 0, h_* 0, all rvalid 0, all rdata 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0.
- Request accepted in cycle t (gnt high) -> ISSUE (mem_we for writes) in t+1 -> RESP in t+2 -> rvalid/rdata in t+3.
- Back-to-back: new gnt possible in RESP cycle t+2, so sustained throughput one access per 2 cycles; alternates m0/m1 when both request continuously.
- Requester may change inputs on the cycle after gnt; a req still high then is a new request.
- req dropped before gnt: no transaction, no side effect.
- Reset asserted mid-transaction (ISSUE or RESP): mem_we deasserts immediately, transaction abandoned, no rvalid; after release, first tie goes to m0.
- rvalid pulses are exactly one cycle, never simultaneous for both masters.

## Test plan
- Reset, then m0 read addr 0x10 with memory word 0x00500093 -> m0_gnt at t, mem_addr=0x10 at t+1, m0_rvalid=1 and m0_rdata=0x00500093 at t+3; m1 outputs stay 0.
- m1 write addr 0x20 data 0xDEADBEEF -> mem_we=1 only in t+1 with mem_addr=0x20/mem_wdata=0xDEADBEEF; m1_rvalid at t+3; readback by m0 returns 0xDEADBEEF.
- Both req continuously (reads 0x0 and 0x4) from reset -> grants m0,m1,m0,m1 every 2 cycles; rvalids alternate, never coincident.
- m0 req held high during ISSUE of an m1 access -> no gnt in ISSUE; m0_gnt in following RESP cycle, m0 ISSUE immediately after.
- Assert reset during ISSUE of a write -> mem_we falls same cycle, no rvalid, state IDLE; post-reset simultaneous requests grant m0 first.
- Idle bus 10 cycles -> busy=0, mem_we=0, no gnt/rvalid.
